// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO of core stores drained to data memory over valid/ready.
// Optional write merging into the youngest non-head entry when STORE_BUF_MERGE_EN is defined.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               write,
   input  logic [31:0]              write_address,
   input  logic [31:0]              DATA_out,
   input  logic                     read,
   input  logic [31:0]              read_address,
   output logic                     hazard,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [31:0]              mem_address,
   output logic [31:0]              mem_data,
   output logic [3:0]               mem_we
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   r_addr [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [3:0]    r_be   [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   logic          w_req;
   logic          w_full;
   logic          w_empty;
   logic          w_deq;
   logic          w_enq;
   logic          w_drop;
   logic          w_merge;
   logic [PW-1:0] w_head_nxt;
   logic [PW-1:0] w_tail_nxt;
   logic [CW-1:0] w_count_nxt;
   logic          w_ovf_nxt;
   logic          w_hit;
   logic [PW-1:0] w_off;
   logic          w_unused_lsbs;

   assign w_req   = |write;
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_deq   = !w_empty && mem_ready;
   assign w_unused_lsbs = &{1'b0, read_address[1:0]};

`ifdef STORE_BUF_MERGE_EN
   logic [PW-1:0] w_young;
   logic [31:0]   w_merge_data;
   logic [3:0]    w_merge_be;

   // Merge target is the youngest entry, only while it is not also the head.
   always_comb begin
      w_young      = r_tail - PW'(1);
      w_merge      = w_req && (r_count >= CW'(2))
                     && (r_addr[w_young][31:2] == write_address[31:2]);
      w_merge_be   = r_be[w_young] | write;
      w_merge_data = r_data[w_young];
      for (int b = 0; b < 4; b++) begin
         if (write[b]) begin
            w_merge_data[8*b +: 8] = DATA_out[8*b +: 8];
         end
      end
   end
`else
   assign w_merge = 1'b0;
`endif

   // Next-state for pointers, occupancy and sticky overflow.
   always_comb begin
      w_enq       = w_req && !w_merge && (!w_full || w_deq);
      w_drop      = w_req && !w_merge && w_full && !w_deq;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_count_nxt = r_count;
      w_ovf_nxt   = r_overflow | w_drop;
      if (w_enq) begin
         w_tail_nxt = r_tail + PW'(1);
      end
      if (w_deq) begin
         w_head_nxt = r_head + PW'(1);
      end
      case ({w_enq, w_deq})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Word-address match against live entries and the store arriving this cycle.
   always_comb begin
      w_hit = 1'b0;
      w_off = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_off = PW'(i) - r_head;
         if ((CW'(w_off) < r_count) && (r_addr[i][31:2] == read_address[31:2])) begin
            w_hit = 1'b1;
         end
      end
      if (w_req && (write_address[31:2] == read_address[31:2])) begin
         w_hit = 1'b1;
      end
      hazard = read && w_hit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_be[i]   <= '0;
         end
      end else begin
         r_head     <= w_head_nxt;
         r_tail     <= w_tail_nxt;
         r_count    <= w_count_nxt;
         r_overflow <= w_ovf_nxt;
         if (w_enq) begin
            r_addr[r_tail] <= write_address;
            r_data[r_tail] <= DATA_out;
            r_be[r_tail]   <= write;
         end
`ifdef STORE_BUF_MERGE_EN
         if (w_merge) begin
            r_data[w_young] <= w_merge_data;
            r_be[w_young]   <= w_merge_be;
         end
`endif
      end
   end

   // Head entry is presented straight from storage; zeroed while empty.
   assign mem_valid   = !w_empty;
   assign mem_address = w_empty ? 32'h0 : r_addr[r_head];
   assign mem_data    = w_empty ? 32'h0 : r_data[r_head];
   assign mem_we      = w_empty ? 4'h0  : r_be[r_head];
   assign full        = w_full;
   assign count       = r_count;
   assign overflow    = r_overflow;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the core's data-store port (`write`, `write_address`, `DATA_out`) and the data memory. Core stores are captured in one cycle into a circular FIFO and drained to memory over a valid/ready handshake. Loads can proceed while stores drain. A combinational hazard flag tells the load path when a read targets a word that still has a pending store.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `write`  in  4  core byte enables; any nonzero value is a store request.
- `write_address`  in  32  core store address.
- `DATA_out`  in  32  core store data, lane-aligned.
- `read`  in  1  core load strobe.
- `read_address`  in  32  core load address.
- `hazard`  out  1  `read` is high and a pending or incoming store matches the load word.
- `full`  out  1  count == `DEPTH`.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `overflow`  out  1  sticky flag: at least one store has been dropped.
- `mem_valid`  out  1  head entry presented to memory.
- `mem_ready`  in  1  memory accepts the head entry.
- `mem_address`  out  32  head entry address.
- `mem_data`  out  32  head entry data.
- `mem_we`  out  4  head entry byte enables.

## Operation
- Storage: `DEPTH` entries of {address, data, byte enables}. Head and tail pointers wrap modulo `DEPTH`. `count` is held as a separate register.
- Enqueue when `write` != 0 and (not `full` or a dequeue happens in the same cycle). The entry is written at the tail and the tail pointer advances.
- Dequeue when `mem_valid` && `mem_ready`. The head pointer advances.
- `mem_valid` = (count != 0). `mem_address`, `mem_data` and `mem_we` always show the head entry. They are 0 whenever count == 0.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when enqueue and dequeue happen in the same cycle, including when full.
- Store while `full` with no dequeue in that cycle: the store is discarded and `overflow` is set. `overflow` clears only on reset.
- `hazard` is combinational. It is set when `read` is high and `read_address[31:2]` equals `[31:2]` of either:
  - any valid entry, or
  - the incoming store in the same cycle.
- Byte enables are not considered when evaluating `hazard`.
- Stores with `write` == 0 are ignored.
- Memory order equals core store order.

## Timing
- Reset values: `hazard` follows its inputs; every other output is 0 (`mem_valid`, `mem_we`, `mem_address`, `mem_data`, `full`, `count`, `overflow`). Pointers are 0.
- Asserting `reset` mid-drain discards all entries, and `mem_valid` drops asynchronously.
- Latency: a store enqueued into an empty buffer at edge N appears with `mem_valid` = 1 after edge N. No combinational path exists from `write` to the `mem_*` outputs.
- Throughput: one enqueue and one dequeue per cycle.
- Handshake:
  - Once `mem_valid` is high, the `mem_*` outputs hold stable until `mem_ready` is sampled high.
  - `mem_ready` while `mem_valid` is low has no effect.
- `full` and `count` are registered and reflect state after the last edge.

## Configuration
- `STORE_BUF_MERGE_EN` defined: write merging is enabled.
  - An incoming store merges into the youngest valid entry when its word address equals that entry's word address, and that entry is not the head (count ≥ 2).
  - Merge result: byte enables are ORed, and data lanes whose incoming enable bit is set are overwritten.
  - A merge does not allocate an entry or change `count`, and it succeeds even when `full`, so `overflow` is not set.
- Macro undefined: every store allocates a new entry, with no merge logic.

## Test plan
- Single store: with `write`=4'b1111, address 0x100, data 0xDEADBEEF and `mem_ready`=1, the `mem_*` outputs show that entry for exactly one cycle starting the next cycle. `count` goes 0→1→0.
- Fill and overflow (DEPTH=4, `mem_ready`=0):
  - Five stores to 0x0, 0x10, 0x20, 0x30, 0x40 → `full`=1, `count`=4, `overflow`=1.
  - Then raise `mem_ready` → drain order is 0x0, 0x10, 0x20, 0x30, and 0x40 never appears.
- Full with simultaneous enqueue and dequeue: with the buffer full and `mem_ready`=1, a store to 0x50 → `count` stays 4, `overflow` stays 0, and 0x50 drains last.
- Hazard:
  - Pending store to 0x204 and `read` of 0x206 → `hazard`=1.
  - `read` of 0x208 → `hazard`=0.
  - A store to 0x300 and a read of 0x300 in the same cycle → `hazard`=1.
- Reset mid-drain: with three entries pending, pulse `reset` low → `mem_valid`, `count` and `overflow` become 0 immediately, and no stale entry drains after release.
- Merge (macro defined):
  - Stall memory with 0x0 at the head.
  - Store 0x10 with `write`=4'b0011, data 0x0000AAAA.
  - Store 0x10 with `write`=4'b1100, data 0xBBBB0000.
  - → `count`=2, and the second entry drains with `mem_we`=4'b1111 and `mem_data`=0xBBBBAAAA.
